// File: rtl/cuca1_sequencer.sv
// Microprogrammed control unit for the cuca1 8-bit accumulator CPU: steps through
// fetch/decode/execute for the opcode in IR and drives the datapath control pins.
module cuca1_sequencer #(
  parameter int BITW       = 8,
  parameter int WAIT_LIMIT = 16
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic [BITW-1:0] ir,
  input  logic            acc_zero,
  input  logic            mem_ready,
  output logic [8:0]      mi,
  output logic            pc_inc,
  output logic            mar_ld,
  output logic [1:0]      alu_op,
  output logic            halted,
  output logic            fault
);

  localparam int ACC_EN = 0;
  localparam int ACC_RW = 1;
  localparam int PC_EN  = 2;
  localparam int PC_RW  = 3;
  localparam int IR_EN  = 4;
  localparam int IR_RW  = 5;
  localparam int MEM_EN = 6;
  localparam int MEM_RW = 7;
  localparam int END    = 8;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_STA = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH0, S_FETCH1, S_DECODE, S_OPER0,
    S_OPER1, S_EXEC, S_DONE, S_HALT, S_FAULT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] opcode;
  logic       take_jump;
  logic       unused_operand;

  assign opcode         = ir[BITW-1 -: 3];
  assign take_jump      = (opcode == OP_JMP) || ((opcode == OP_JZ) && acc_zero);
  assign unused_operand = ^ir[BITW-4:0];

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    mi         = '0;
    pc_inc     = 1'b0;
    mar_ld     = 1'b0;
    alu_op     = 2'b00;
    halted     = 1'b0;
    fault      = 1'b0;

    unique case (state_q)
      S_RESET: state_d = S_FETCH0;
      S_FETCH0, S_OPER0: begin
        mi[PC_EN] = 1'b1;
        mar_ld    = 1'b1;
        state_d   = (state_q == S_FETCH0) ? S_FETCH1 : S_OPER1;
      end
      S_FETCH1: begin
        mi[MEM_EN] = 1'b1;
        mi[IR_EN]  = 1'b1;
        mi[IR_RW]  = 1'b1;
        if (mem_ready) begin
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_NOP)      state_d = S_DONE;
        else if (opcode == OP_HLT) state_d = S_HALT;
        else                       state_d = S_OPER0;
      end
      S_OPER1: begin
        mi[MEM_EN] = 1'b1;
        if (take_jump) begin
          // The operand byte goes straight into PC, so PC must not also increment.
          mi[PC_EN] = 1'b1;
          mi[PC_RW] = 1'b1;
          if (mem_ready) state_d = S_DONE;
        end else if (opcode == OP_JZ) begin
          if (mem_ready) begin
            pc_inc  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          mar_ld = 1'b1;
          if (mem_ready) begin
            pc_inc  = 1'b1;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        mi[MEM_EN] = 1'b1;
        mi[ACC_EN] = 1'b1;
        if (opcode == OP_STA) begin
          mi[MEM_RW] = 1'b1;
        end else begin
          mi[ACC_RW] = 1'b1;
          if (opcode == OP_ADD)      alu_op = 2'b01;
          else if (opcode == OP_SUB) alu_op = 2'b10;
        end
        if (mem_ready) state_d = S_DONE;
      end
      S_DONE: begin
        mi[END] = 1'b1;
        state_d = S_FETCH0;
      end
      S_HALT: halted = 1'b1;
      S_FAULT: begin
        halted = 1'b1;
        fault  = 1'b1;
      end
      default: state_d = S_RESET;
    endcase

    // Memory states share one timeout; a ready in the last allowed cycle still completes.
    if ((state_q == S_FETCH1 || state_q == S_OPER1 || state_q == S_EXEC) && !mem_ready) begin
      if (wait_cnt_q == WAIT_LAST) state_d = S_FAULT;
      else                         wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_cuca1_sequencer.sv
// Scoreboard bench for cuca1_sequencer: a per-instruction transfer model plans every
// cycle's inputs and expected control pins; a monitor compares each cycle.
module tb_cuca1_sequencer;
  localparam int WL = 4;
  localparam int R_OK = 0;
  localparam int R_HALT = 1;
  localparam int R_FAULT = 2;

  logic       clock = 1'b0;
  logic       n_reset;
  logic [7:0] ir;
  logic       acc_zero;
  logic       mem_ready;
  logic [8:0] mi;
  logic       pc_inc;
  logic       mar_ld;
  logic [1:0] alu_op;
  logic       halted;
  logic       fault;

  cuca1_sequencer #(.BITW(8), .WAIT_LIMIT(WL)) dut (
    .clock(clock), .n_reset(n_reset), .ir(ir), .acc_zero(acc_zero),
    .mem_ready(mem_ready), .mi(mi), .pc_inc(pc_inc), .mar_ld(mar_ld),
    .alu_op(alu_op), .halted(halted), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       nrst;
    logic [7:0] ir;
    logic       az;
    logic       mr;
    logic       chk;
    logic [8:0] mi;
    logic       pc_inc;
    logic       mar_ld;
    logic [1:0] alu;
    logic       halted;
    logic       fault;
  } cyc_t;

  cyc_t plan[$];
  cyc_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic [7:0] g_ir;
  logic       g_az;
  logic       g_pin_az;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void put(input logic mr, input logic [8:0] m, input logic inc,
                              input logic mar, input logic [1:0] alu,
                              input logic h, input logic f);
    cyc_t c;
    c.nrst = 1'b1;  c.ir = g_ir;  c.az = g_pin_az ? g_az : rbit();
    c.mr = mr;      c.chk = 1'b1; c.mi = m;  c.pc_inc = inc;  c.mar_ld = mar;
    c.alu = alu;    c.halted = h; c.fault = f;
    plan.push_back(c);
  endfunction

  function automatic void mark_last(input logic nrst, input logic chk);
    cyc_t c;
    c = plan.pop_back();
    c.nrst = nrst;
    c.chk  = chk;
    plan.push_back(c);
  endfunction

  // Remaining cycles of a reset pulse (n cycles low in total) plus the release cycle.
  function automatic void reset_tail(input int n);
    for (int i = 0; i < n - 1; i++) begin
      put(rbit(), 9'h000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      mark_last(1'b0, 1'b1);
    end
    put(rbit(), 9'h000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endfunction

  // One bus access to memory: `waits` not-ready cycles, then completion; 1 on timeout.
  function automatic logic mem(input logic [8:0] m, input logic mar, input logic [1:0] alu,
                               input logic inc, input int waits);
    int n;
    n = (waits >= WL) ? WL : waits;
    for (int i = 0; i < n; i++) put(1'b0, m, 1'b0, mar, alu, 1'b0, 1'b0);
    if (waits >= WL) return 1'b1;
    put(1'b1, m, inc, mar, alu, 1'b0, 1'b0);
    return 1'b0;
  endfunction

  // Instruction as register transfers: MAR<-PC, IR<-M[MAR], decode, then operand/execute.
  function automatic int instr(input logic [2:0] op, input logic az,
                               input int w0, input int w1, input int w2);
    logic       jump;
    logic       to;
    logic [1:0] alu;
    g_az = az;
    g_pin_az = 1'b0;
    g_ir = 8'($urandom);
    put(rbit(), 9'h004, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    g_ir = 8'($urandom);
    if (mem(9'h070, 1'b0, 2'b00, 1'b1, w0)) return R_FAULT;
    g_ir = {op, 5'($urandom)};
    put(rbit(), 9'h000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    if (op == 3'd7) return R_HALT;
    if (op != 3'd0) begin
      put(rbit(), 9'h004, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      jump = (op == 3'd5) || ((op == 3'd6) && az);
      g_pin_az = 1'b1;
      if (op == 3'd5 || op == 3'd6)
        to = mem(jump ? 9'h04C : 9'h040, 1'b0, 2'b00, !jump, w1);
      else
        to = mem(9'h040, 1'b1, 2'b00, 1'b1, w1);
      g_pin_az = 1'b0;
      if (to) return R_FAULT;
      if (op >= 3'd1 && op <= 3'd4) begin
        alu = (op == 3'd3) ? 2'b01 : (op == 3'd4) ? 2'b10 : 2'b00;
        if (mem((op == 3'd2) ? 9'h0C1 : 9'h043, 1'b0, alu, 1'b0, w2)) return R_FAULT;
      end
    end
    put(rbit(), 9'h100, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    return R_OK;
  endfunction

  function automatic void stop_then_reset(input int kind, input int k, input int n);
    for (int i = 0; i < k; i++) begin
      g_ir = 8'($urandom);
      put(rbit(), 9'h000, 1'b0, 1'b0, 2'b00, 1'b1, kind == R_FAULT);
    end
    mark_last(1'b0, 1'b1);
    reset_tail(n);
  endfunction

  function automatic void cut_and_reset(input int s, input int len, input int n);
    while (plan.size() > s + len) void'(plan.pop_back());
    mark_last(1'b0, 1'b1);
    reset_tail(n);
  endfunction

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return 0;
    if (r < 95) return $urandom_range(1, WL - 1);
    return WL;
  endfunction

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  cyc_t e;
  int   cyc_n = 0;
  initial begin
    logic [14:0] got, want;
    int drivers;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          got  = {mi, pc_inc, mar_ld, alu_op, halted, fault};
          want = {e.mi, e.pc_inc, e.mar_ld, e.alu, e.halted, e.fault};
          total++;
          if (got !== want) begin
            bad++;
            $display("FAIL cycle%0d outputs got={mi,pc_inc,mar_ld,alu,halted,fault}=%h want=%h",
                     cyc_n, got, want);
          end
          drivers = int'(mi[0] & ~mi[1]) + int'(mi[2] & ~mi[3]) +
                    int'(mi[4] & ~mi[5]) + int'(mi[6] & ~mi[7]);
          total++;
          if (drivers > 1 || (mi[4] && !mi[5]) || (pc_inc && mi[3])) begin
            bad++;
            $display("FAIL cycle%0d bus_rules mi=%h pc_inc=%b drivers=%0d required<=1",
                     cyc_n, mi, pc_inc, drivers);
          end
        end
        cyc_n++;
      end
    end
  end

  initial begin
    int s, r;
    n_reset = 1'b0; ir = 8'h00; acc_zero = 1'b0; mem_ready = 1'b0;
    g_ir = 8'h00; g_az = 1'b0; g_pin_az = 1'b0;

    // Power-on reset, then a run of NOPs with memory always ready.
    put(1'b1, 9'h000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    mark_last(1'b0, 1'b0);
    reset_tail(3);
    for (int i = 0; i < 3; i++) void'(instr(3'd0, 1'b0, 0, 0, 0));
    void'(instr(3'd1, 1'b0, 0, 0, 2));
    void'(instr(3'd6, 1'b1, 0, 0, 0));
    void'(instr(3'd6, 1'b0, 0, 0, 0));
    void'(instr(3'd5, 1'b0, 1, 1, 0));
    void'(instr(3'd2, 1'b0, 0, 0, 1));
    r = instr(3'd7, 1'b0, 0, 0, 0);
    stop_then_reset(r, 5, 2);
    r = instr(3'd0, 1'b0, WL, 0, 0);
    stop_then_reset(r, 4, 1);
    void'(instr(3'd0, 1'b0, WL - 1, 0, 0));
    r = instr(3'd1, 1'b0, 0, WL, 0);
    stop_then_reset(r, 2, 1);
    r = instr(3'd4, 1'b0, 0, 0, WL);
    stop_then_reset(r, 2, 1);
    void'(instr(3'd3, 1'b0, 0, 0, 0));
    void'(instr(3'd4, 1'b0, 0, 0, 0));
    // Reset in the first EXEC cycle of an ADD.
    s = plan.size();
    void'(instr(3'd3, 1'b0, 0, 0, 2));
    cut_and_reset(s, 6, 2);

    for (int i = 0; i < 250; i++) begin
      s = plan.size();
      r = instr(3'($urandom), rbit(), pick_wait(), pick_wait(), pick_wait());
      if (r != R_OK)
        stop_then_reset(r, $urandom_range(1, 4), $urandom_range(1, 3));
      else if ($urandom_range(0, 19) == 0)
        cut_and_reset(s, $urandom_range(1, plan.size() - s), $urandom_range(1, 3));
    end

    foreach (plan[i]) begin
      @(posedge clock);
      #1;
      n_reset   = plan[i].nrst;
      ir        = plan[i].ir;
      acc_zero  = plan[i].az;
      mem_ready = plan[i].mr;
      exp_q.push_back(plan[i]);
    end
    @(negedge clock);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cuca1_sequencer.md
Name: cuca1_sequencer

Overview:
- Microprogrammed control unit for the cuca1 8-bit accumulator CPU.
- Sits directly upstream of the datapath. Each cycle it drives the control-pin vector that enables registers and memory and selects their bus direction.
- Runs FETCH / DECODE / EXECUTE sequences from the opcode held in IR.
- Stalls on memory wait states and halts on HLT or on a memory timeout.

Parameters:
- BITW, 8, datapath/IR width.
- WAIT_LIMIT, 16, consecutive mem_ready-low cycles in one memory state before the fault halt (range 1..255).

Ports:
- clock  in  1  clock
- n_reset  in  1  reset, synchronous, active-low
- ir  in  BITW  instruction register contents; opcode = ir[BITW-1:BITW-3]
- acc_zero  in  1  accumulator == 0 flag
- mem_ready  in  1  memory completes the current access this cycle
- mi  out  9  control pins, bit order:
  - 0 ACC_EN, 1 ACC_RW, 2 PC_EN, 3 PC_RW, 4 IR_EN, 5 IR_RW, 6 MEM_EN, 7 MEM_RW, 8 END
  - EN = unit takes part in the bus transfer; RW = 1 loads from bus (memory: write), 0 drives bus
- pc_inc  out  1  PC increments at this clock edge
- mar_ld  out  1  MAR loads from bus
- alu_op  out  2  00 pass, 01 add, 10 sub (applies when ACC loads)
- halted  out  1  sequencer stopped
- fault  out  1  stopped due to memory timeout

Behaviour:
- Opcodes: 000 NOP, 001 LDA a, 010 STA a, 011 ADD a, 100 SUB a, 101 JMP a, 110 JZ a, 111 HLT. ir[BITW-4:0] is ignored.
- Operand instructions are 2 bytes: opcode byte, then address byte.
- States: RESET, FETCH0, FETCH1, DECODE, OPER0, OPER1, EXEC, DONE, HALT, FAULT.
- State register and wait counter are registered. All outputs are decoded combinationally from state, ir, acc_zero and mem_ready.
- Any output not listed for a state is 0.
- Reset:
  - n_reset=0 at a rising edge → state=RESET, wait counter=0, regardless of current state (including mid-instruction, HALT, FAULT).
  - RESET drives all outputs 0 and goes to FETCH0 on the first edge with n_reset=1.
- FETCH0: PC_EN=1, PC_RW=0, mar_ld=1 → FETCH1.
- FETCH1: MEM_EN=1, MEM_RW=0, IR_EN=1, IR_RW=1.
  - mem_ready=1: pc_inc=1 → DECODE.
  - Otherwise stay, with outputs held.
- DECODE: all outputs 0.
  - NOP → DONE.
  - HLT → HALT.
  - Others → OPER0.
- OPER0: PC_EN=1, PC_RW=0, mar_ld=1 → OPER1.
- OPER1: MEM_EN=1, MEM_RW=0.
  - JMP, or JZ with acc_zero=1: PC_EN=1, PC_RW=1, no pc_inc; on mem_ready → DONE.
  - JZ with acc_zero=0: pc_inc on mem_ready → DONE.
  - LDA/STA/ADD/SUB: mar_ld=1, pc_inc on mem_ready → EXEC.
  - pc_inc is asserted only in the mem_ready=1 cycle.
- EXEC, waits on mem_ready:
  - LDA: MEM_EN=1, MEM_RW=0, ACC_EN=1, ACC_RW=1, alu_op=00.
  - STA: ACC_EN=1, ACC_RW=0, MEM_EN=1, MEM_RW=1.
  - ADD/SUB: as LDA with alu_op=01/10.
  - On mem_ready → DONE.
- DONE: END=1 for exactly one cycle → FETCH0.
- HALT: halted=1, all mi=0; stays until reset.
- FAULT: halted=1, fault=1, all mi=0; stays until reset.
- Wait counter (memory states FETCH1, OPER1, EXEC):
  - Increments each cycle mem_ready=0; clears on leaving the state.
  - If mem_ready=0 and counter==WAIT_LIMIT-1 → FAULT at the next edge.
  - mem_ready=1 in the limit cycle wins: normal transition.
- Latency with no wait states: NOP 4 cycles, JMP/JZ 6, LDA/STA/ADD/SUB 7, FETCH0 to FETCH0. Each wait cycle adds 1.
- Invariant: at most one bus driver per cycle. Drivers are any *_EN=1 with RW=0 among ACC, PC, IR, MEM.
- Invariants: IR_RW=0 with IR_EN=1 never occurs; pc_inc and PC_RW=1 are never asserted together.
- acc_zero is sampled only in OPER1 for JZ.

Test Plan:
- Reset held 3 cycles, then released, ir=0x00, mem_ready=1 → mi=0 during reset; FETCH0 (mi=0x004, mar_ld=1) one cycle after release; END pulses 4 cycles later; repeats every 4 cycles.
- LDA (ir=0x20), mem_ready low 2 cycles in EXEC → EXEC mi=0x043, alu_op=00 held for 3 cycles; END 9 cycles after FETCH0; pc_inc exactly twice.
- JZ (ir=0xC0): acc_zero=1 → OPER1 mi=0x04C, no pc_inc, 6-cycle instruction. acc_zero=0 → OPER1 mi=0x040, pc_inc=1.
- STA (ir=0x40) then HLT (ir=0xE0) → STA EXEC mi=0x0C1; after HLT DECODE, halted=1 and mi=0 forever; reset restarts at FETCH0.
- WAIT_LIMIT=4, mem_ready stuck 0 in FETCH1 → FAULT after 4 FETCH1 cycles, fault=1, halted=1. A repeat with mem_ready=1 on the 4th cycle proceeds to DECODE.
- n_reset=0 during ADD EXEC (ir=0x60) → next cycle all outputs 0, no END pulse, restart at FETCH0; the one-driver assertion holds across a random opcode stream.
